// File: rtl/difftest_step_pkg.sv
// Shared types, limits and the parameter width check for the difftest step scheduler.
`ifndef DIFFTEST_STEP_WIDTH_CHECK
`define DIFFTEST_STEP_WIDTH_CHECK(NR, IW, SW) \
  if ((NR) * ((1 << (IW)) - 1) > ((1 << (SW)) - 1)) begin : g_width_check \
    $error("difftest_step: NUM_REQ*(2^IN_W-1) exceeds 2^STEP_W-1"); \
  end
`endif

package difftest_step_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } step_state_t;

  // Largest value representable in a step word of the given width.
  function automatic int unsigned step_max(input int unsigned step_w);
    return (32'd1 << step_w) - 32'd1;
  endfunction

endpackage

// File: rtl/difftest_step_adder.sv
// Valid-masked reduction of the packed per-requester step increments.
module difftest_step_adder
  import difftest_step_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IN_W    = 4,
  parameter int STEP_W  = 8
) (
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_step,
  output logic [STEP_W:0]         sum
);

  logic [STEP_W:0] sum_s;

  // Accumulate only the lanes whose valid bit is set.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        sum_s = sum_s + (STEP_W+1)'(req_step[i*IN_W +: IN_W]);
      end else begin
        sum_s = sum_s;
      end
    end
  end

  assign sum = sum_s;

endmodule

// File: rtl/difftest_step_scheduler.sv
// Batches per-cycle commit-step increments into one registered step word,
// flushing on threshold, timeout or drain, and freezing once a stop result arrives.
module difftest_step_scheduler
  import difftest_step_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IN_W    = 4,
  parameter int STEP_W  = 8,
  parameter int THRESH  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_step,
  input  logic                    drain,
  input  logic [7:0]              simv_result,
  output logic [STEP_W-1:0]       step,
  output logic [STEP_W:0]         pending,
  output logic                    halted
);

  localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [STEP_W:0]    STEP_MAX_EXT = (STEP_W+1)'(step_max(STEP_W));
  localparam logic [STEP_W:0]    THRESH_EXT   = (STEP_W+1)'(THRESH);
  localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(TIMEOUT - 1);

  `DIFFTEST_STEP_WIDTH_CHECK(NUM_REQ, IN_W, STEP_W)

  step_state_t        state_r, state_s;
  logic [STEP_W:0]    acc_r, acc_s;
  logic [TIMER_W-1:0] timer_r, timer_s;
  logic [STEP_W-1:0]  step_r, step_s;
  logic               halted_r;
  logic [STEP_W:0]    sum_s;
  logic [STEP_W:0]    next_s;
  logic [STEP_W:0]    emit_s;
  logic               flush_s;

  difftest_step_adder #(
    .NUM_REQ (NUM_REQ),
    .IN_W    (IN_W),
    .STEP_W  (STEP_W)
  ) u_adder (
    .req_valid (req_valid),
    .req_step  (req_step),
    .sum       (sum_s)
  );

  // Candidate accumulator value and flush decision for this cycle.
  always_comb begin
    next_s  = acc_r + sum_s;
    flush_s = (next_s >= THRESH_EXT)
           || ((timer_r == TIMER_LAST) && (next_s != '0))
           || (drain && (next_s != '0))
           || (next_s > STEP_MAX_EXT);
    if (next_s > STEP_MAX_EXT) begin
      emit_s = STEP_MAX_EXT;
    end else begin
      emit_s = next_s;
    end
  end

  // Next-state and datapath update; a stop result takes priority over any flush.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    timer_s = timer_r;
    step_s  = '0;
    case (state_r)
      RUN: begin
        if (simv_result != 8'd0) begin
          state_s = HALT;
        end else if (flush_s) begin
          step_s  = emit_s[STEP_W-1:0];
          acc_s   = next_s - emit_s;
          timer_s = '0;
        end else begin
          acc_s = next_s;
          if (next_s != '0) begin
            timer_s = timer_r + TIMER_W'(1);
          end else begin
            timer_s = '0;
          end
        end
      end
      HALT: begin
        state_s = HALT;
      end
      default: begin
        state_s = HALT;
      end
    endcase
  end

  // State, accumulator, timer and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= RUN;
      acc_r    <= '0;
      timer_r  <= '0;
      step_r   <= '0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      timer_r  <= timer_s;
      step_r   <= step_s;
      halted_r <= (state_s == HALT);
    end
  end

  assign step    = step_r;
  assign pending = acc_r;
  assign halted  = halted_r;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Directed self-checking bench: instance A uses the default widths with TIMEOUT=16,
// instance B uses a 4-bit step word to exercise saturation and carry.
module tb_difftest_step_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic [1:0] a_valid = 2'b00;
  logic [7:0] a_step  = 8'h00;
  logic       a_drain = 1'b0;
  logic [7:0] a_res   = 8'h00;
  logic [7:0] a_out;
  logic [8:0] a_pend;
  logic       a_halted;

  logic [1:0] b_valid = 2'b00;
  logic [5:0] b_step  = 6'h00;
  logic       b_drain = 1'b0;
  logic [7:0] b_res   = 8'h00;
  logic [3:0] b_out;
  logic [4:0] b_pend;
  logic       b_halted;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  difftest_step_scheduler #(
    .NUM_REQ (2), .IN_W (4), .STEP_W (8), .THRESH (64), .TIMEOUT (16)
  ) dut_a (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (a_valid),
    .req_step    (a_step),
    .drain       (a_drain),
    .simv_result (a_res),
    .step        (a_out),
    .pending     (a_pend),
    .halted      (a_halted)
  );

  difftest_step_scheduler #(
    .NUM_REQ (2), .IN_W (3), .STEP_W (4), .THRESH (15), .TIMEOUT (256)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (b_valid),
    .req_step    (b_step),
    .drain       (b_drain),
    .simv_result (b_res),
    .step        (b_out),
    .pending     (b_pend),
    .halted      (b_halted)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    a_valid = 2'b00;
    a_step  = 8'h00;
    a_drain = 1'b0;
    a_res   = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (a_out !== 8'd0 || a_pend !== 9'd0 || a_halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: step=%0d pending=%0d halted=%0b, required 0/0/0", a_out, a_pend, a_halted);
    end
    checks++;
    if (b_out !== 4'd0 || b_pend !== 5'd0 || b_halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: step=%0d pending=%0d halted=%0b, required 0/0/0", b_out, b_pend, b_halted);
    end
  endtask

  task automatic test_threshold();
    logic [7:0] exp_step;
    logic [8:0] exp_pend;
    a_valid = 2'b11;
    a_step  = {4'd8, 4'd8};
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_step = ((c % 4) == 0) ? 8'd64 : 8'd0;
      exp_pend = 9'(16 * (c % 4));
      checks++;
      if (a_out !== exp_step || a_pend !== exp_pend) begin
        errors++;
        $display("FAIL threshold cycle %0d: step=%0d pending=%0d, required %0d/%0d", c, a_out, a_pend, exp_step, exp_pend);
      end
    end
    idle_a();
    tick();
    checks++;
    if (a_out !== 8'd0 || a_pend !== 9'd0) begin
      errors++;
      $display("FAIL threshold_idle: step=%0d pending=%0d, required 0/0", a_out, a_pend);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_step;
    a_valid = 2'b01;
    a_step  = {4'd0, 4'd3};
    tick();
    idle_a();
    checks++;
    if (a_out !== 8'd0 || a_pend !== 9'd3) begin
      errors++;
      $display("FAIL timeout_load: step=%0d pending=%0d, required 0/3", a_out, a_pend);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_step = (k == 15) ? 8'd3 : 8'd0;
      checks++;
      if (a_out !== exp_step) begin
        errors++;
        $display("FAIL timeout cycle %0d: step=%0d, required %0d", k, a_out, exp_step);
      end
    end
    checks++;
    if (a_pend !== 9'd0) begin
      errors++;
      $display("FAIL timeout_pending: pending=%0d, required 0", a_pend);
    end
  endtask

  task automatic test_carry();
    b_valid = 2'b11;
    b_step  = {3'd6, 3'd6};
    tick();
    checks++;
    if (b_out !== 4'd0 || b_pend !== 5'd12) begin
      errors++;
      $display("FAIL carry_load: step=%0d pending=%0d, required 0/12", b_out, b_pend);
    end
    b_step = {3'd5, 3'd5};
    tick();
    checks++;
    if (b_out !== 4'd15 || b_pend !== 5'd7) begin
      errors++;
      $display("FAIL carry_saturate: step=%0d pending=%0d, required 15/7", b_out, b_pend);
    end
    b_valid = 2'b00;
    b_step  = 6'h00;
    b_drain = 1'b1;
    tick();
    checks++;
    if (b_out !== 4'd7 || b_pend !== 5'd0) begin
      errors++;
      $display("FAIL carry_drain: step=%0d pending=%0d, required 7/0", b_out, b_pend);
    end
    b_drain = 1'b0;
    tick();
    checks++;
    if (b_out !== 4'd0) begin
      errors++;
      $display("FAIL carry_single_cycle: step=%0d, required 0", b_out);
    end
  endtask

  task automatic test_halt();
    a_valid = 2'b11;
    a_step  = {4'd10, 4'd10};
    tick();
    checks++;
    if (a_pend !== 9'd20 || a_out !== 8'd0) begin
      errors++;
      $display("FAIL halt_load: step=%0d pending=%0d, required 0/20", a_out, a_pend);
    end
    a_step  = {4'd5, 4'd5};
    a_drain = 1'b1;
    a_res   = 8'h01;
    tick();
    checks++;
    if (a_out !== 8'd0 || a_halted !== 1'b1 || a_pend !== 9'd20) begin
      errors++;
      $display("FAIL halt_wins: step=%0d halted=%0b pending=%0d, required 0/1/20", a_out, a_halted, a_pend);
    end
    a_res   = 8'h00;
    a_drain = 1'b0;
    a_step  = {4'd15, 4'd15};
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (a_out !== 8'd0 || a_halted !== 1'b1 || a_pend !== 9'd20) begin
        errors++;
        $display("FAIL halt_frozen %0d: step=%0d halted=%0b pending=%0d, required 0/1/20", k, a_out, a_halted, a_pend);
      end
    end
    idle_a();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    checks++;
    if (a_halted !== 1'b0 || a_pend !== 9'd0) begin
      errors++;
      $display("FAIL halt_cleared: halted=%0b pending=%0d, required 0/0", a_halted, a_pend);
    end
  endtask

  task automatic test_masking();
    a_valid = 2'b01;
    a_step  = {4'hF, 4'h2};
    tick();
    checks++;
    if (a_pend !== 9'd2 || a_out !== 8'd0) begin
      errors++;
      $display("FAIL mask_lane0: step=%0d pending=%0d, required 0/2", a_out, a_pend);
    end
    a_valid = 2'b10;
    a_step  = {4'h3, 4'hA};
    tick();
    checks++;
    if (a_pend !== 9'd5) begin
      errors++;
      $display("FAIL mask_lane1: pending=%0d, required 5", a_pend);
    end
    idle_a();
    a_drain = 1'b1;
    tick();
    checks++;
    if (a_out !== 8'd5 || a_pend !== 9'd0) begin
      errors++;
      $display("FAIL mask_drain: step=%0d pending=%0d, required 5/0", a_out, a_pend);
    end
    idle_a();
    tick();
  endtask

  task automatic test_async_reset();
    a_valid = 2'b11;
    a_step  = {4'd15, 4'd15};
    tick();
    idle_a();
    checks++;
    if (a_pend !== 9'd30) begin
      errors++;
      $display("FAIL async_load: pending=%0d, required 30", a_pend);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (a_pend !== 9'd0 || a_out !== 8'd0 || a_halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: step=%0d pending=%0d halted=%0b, required 0/0/0", a_out, a_pend, a_halted);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (a_pend !== 9'd0 || a_out !== 8'd0) begin
      errors++;
      $display("FAIL async_after: step=%0d pending=%0d, required 0/0", a_out, a_pend);
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_timeout();
    test_carry();
    test_halt();
    test_masking();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
